// File: rtl/usb_reg_pkg.sv
// usb_reg_pkg: shared register map, packet codes and FSM states for
// the endpoint register bank and its byte serializer.
package usb_reg_pkg;

    typedef enum logic [3:0] {
        SEL_DATA     = 4'd0,
        SEL_STATUS   = 4'd1,
        SEL_ERROR    = 4'd2,
        SEL_OCCUP    = 4'd3,
        SEL_TX_CTRL  = 4'd4,
        SEL_FLUSH    = 4'd5,
        SEL_IRQ_MASK = 4'd6
    } reg_sel_e;

    typedef enum logic [2:0] {
        RX_OUT   = 3'd0,
        RX_IN    = 3'd1,
        RX_DATA0 = 3'd2,
        RX_DATA1 = 3'd3,
        RX_ACK   = 3'd4,
        RX_NAK   = 3'd5,
        RX_STALL = 3'd6
    } rx_pkt_e;

    typedef enum logic [1:0] {
        TX_ACK   = 2'd0,
        TX_NAK   = 2'd1,
        TX_DATA  = 2'd2,
        TX_STALL = 2'd3
    } tx_pkt_e;

    localparam logic [2:0] TXC_DATA  = 3'd1;
    localparam logic [2:0] TXC_ACK   = 3'd2;
    localparam logic [2:0] TXC_NAK   = 3'd3;
    localparam logic [2:0] TXC_STALL = 3'd4;

    localparam int ST_RDY = 0;
    localparam int ST_IN  = 1;
    localparam int ST_OUT = 2;
    localparam int ST_ACK = 3;
    localparam int ST_NAK = 4;

    localparam int ER_RX  = 0;
    localparam int ER_TX  = 1;
    localparam int ER_OVF = 2;
    localparam int ER_UNF = 3;

    typedef enum logic [1:0] {
        TX_IDLE, TX_ARM, TX_LAUNCH, TX_ACTIVE
    } tx_state_e;

    typedef enum logic [1:0] {
        SER_IDLE, SER_WR, SER_RD, SER_DONE
    } ser_state_e;

    function automatic tx_pkt_e tx_map(input logic [2:0] code);
        case (code)
            TXC_DATA: tx_map = TX_DATA;
            TXC_ACK:  tx_map = TX_ACK;
            TXC_NAK:  tx_map = TX_NAK;
            default:  tx_map = TX_STALL;
        endcase
    endfunction

endpackage

// File: rtl/usb_ep_reg_bank_if.sv
// usb_ep_reg_bank_if: decoded bus access channel between the AHB-lite
// slave decoder (master) and the endpoint register bank (slave).
interface usb_ep_reg_bank_if #(
    parameter int DATA_W = 32
);
    logic              access_valid;
    logic              access_write;
    logic [1:0]        access_size;
    logic [3:0]        reg_sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;

    modport master (
        output access_valid, access_write, access_size,
        output reg_sel, wdata,
        input  rdata, rdata_valid, busy
    );

    modport slave (
        input  access_valid, access_write, access_size,
        input  reg_sel, wdata,
        output rdata, rdata_valid, busy
    );
endinterface

// File: rtl/usb_byte_serializer.sv
// usb_byte_serializer: turns one DATA access into LSB-first byte
// push or pop strobes toward the endpoint FIFO.
module usb_byte_serializer
    import usb_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_wr_i,
    input  logic              start_rd_i,
    input  logic [IDX_W-1:0]  last_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [7:0]        rx_data_i,
    output logic              busy_o,
    output logic              push_o,
    output logic              pop_o,
    output logic              done_o,
    output logic [7:0]        tx_data_o,
    output logic [DATA_W-1:0] rdata_o
);
    ser_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_q;
    logic [DATA_W-1:0] shift_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            shift_q <= '0;
        end else begin
            unique case (state_q)
                SER_IDLE: begin
                    idx_q  <= '0;
                    last_q <= last_i;
                    if (start_wr_i) begin
                        state_q <= SER_WR;
                        shift_q <= wdata_i;
                    end else if (start_rd_i) begin
                        state_q <= SER_RD;
                        shift_q <= '0;
                    end
                end
                SER_WR: begin
                    shift_q <= shift_q >> 8;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == last_q) state_q <= SER_IDLE;
                end
                SER_RD: begin
                    // Byte k lands in lane k, upper lanes stay zero
                    shift_q[{idx_q, 3'b000} +: 8] <= rx_data_i;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == last_q) state_q <= SER_DONE;
                end
                SER_DONE: state_q <= SER_IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q != SER_IDLE);
    assign push_o    = (state_q == SER_WR);
    assign pop_o     = (state_q == SER_RD);
    assign done_o    = (state_q == SER_DONE);
    assign tx_data_o = push_o ? shift_q[7:0] : 8'h00;
    assign rdata_o   = shift_q;
endmodule

// File: rtl/usb_ep_reg_bank.sv
// usb_ep_reg_bank: endpoint register bank with FIFO burst serializing.
// Define USB_EP_IRQ_EN to add the IRQ_MASK register and irq output.
module usb_ep_reg_bank
    import usb_reg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 64,
    parameter int OCC_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    usb_ep_reg_bank_if.slave bus,
    input  logic [2:0]       rx_packet,
    input  logic             rx_data_ready,
    input  logic             rx_transfer_active,
    input  logic             rx_error,
    input  logic             tx_transfer_active,
    input  logic             tx_error,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic [7:0]       rx_data,
    output logic             get_rx_data,
    output logic             store_tx_data,
    output logic [7:0]       tx_data,
    output logic [1:0]       tx_packet,
    output logic             tx_start,
    output logic             clear,
    output logic             d_mode,
    output logic             irq
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(BYTES);

    reg_sel_e          sel;
    logic              acc, rd, wr, is_data;
    logic [31:0]       n_bytes, occ32;
    logic              ovf, unf, occ_zero;
    logic              ser_busy, ser_done;
    logic [DATA_W-1:0] ser_rdata;
    logic [4:0]        status_q, st_set;
    logic [3:0]        error_q, er_set;
    logic              flush_q;
    logic [DATA_W-1:0] rmux, rdata_q;
    logic              rv_q;
    tx_state_e         tx_state_q;
    logic [2:0]        tx_ctrl_q;
    logic              seen_q, tx_start_q, tx_load, tx_go;
    tx_pkt_e           tx_packet_q;

    assign sel      = reg_sel_e'(bus.reg_sel);
    assign acc      = bus.access_valid & ~bus.busy;
    assign rd       = acc & ~bus.access_write;
    assign wr       = acc & bus.access_write;
    assign is_data  = (sel == SEL_DATA);
    assign occ32    = 32'(buffer_occupancy);
    assign occ_zero = (buffer_occupancy == '0);

    always_comb begin
        n_bytes = 32'd1 << bus.access_size;
        if (n_bytes > 32'(BYTES)) n_bytes = 32'(BYTES);
    end

    assign ovf = n_bytes > (32'(BUF_DEPTH) - occ32);
    assign unf = occ32 < n_bytes;

    usb_byte_serializer #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_ser (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_wr_i (wr & is_data & ~ovf),
        .start_rd_i (rd & is_data & ~unf),
        .last_i     (IDX_W'(n_bytes - 32'd1)),
        .wdata_i    (bus.wdata),
        .rx_data_i  (rx_data),
        .busy_o     (ser_busy),
        .push_o     (store_tx_data),
        .pop_o      (get_rx_data),
        .done_o     (ser_done),
        .tx_data_o  (tx_data),
        .rdata_o    (ser_rdata)
    );

    always_comb begin
        st_set = '0;
        if (rx_data_ready) begin
            st_set[ST_RDY] = (rx_packet == RX_DATA0) || (rx_packet == RX_DATA1);
            st_set[ST_IN]  = (rx_packet == RX_IN);
            st_set[ST_OUT] = (rx_packet == RX_OUT);
            st_set[ST_ACK] = (rx_packet == RX_ACK);
            st_set[ST_NAK] = (rx_packet == RX_NAK);
        end
        er_set         = '0;
        er_set[ER_RX]  = rx_error;
        er_set[ER_TX]  = tx_error;
        er_set[ER_OVF] = wr & is_data & ovf;
        er_set[ER_UNF] = rd & is_data & unf;
    end

    // Sticky bits: a new event in the clearing read cycle survives it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
            error_q  <= '0;
        end else begin
            status_q[4:1] <= ((rd && sel == SEL_STATUS) ? 4'b0 : status_q[4:1])
                           | st_set[4:1];
            if (st_set[ST_RDY]) status_q[ST_RDY] <= 1'b1;
            else if (occ_zero)  status_q[ST_RDY] <= 1'b0;
            error_q <= ((rd && sel == SEL_ERROR) ? 4'b0 : error_q) | er_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 1'b0;
        end else if (flush_q && occ_zero) begin
            flush_q <= 1'b0;
        end else if (wr && sel == SEL_FLUSH && bus.wdata != '0) begin
            flush_q <= 1'b1;
        end
    end

    assign tx_load = wr && sel == SEL_TX_CTRL && tx_ctrl_q == '0
                  && bus.wdata != '0 && bus.wdata <= DATA_W'(4);
    assign tx_go   = !tx_transfer_active
                  && (tx_ctrl_q != TXC_DATA || !occ_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_ctrl_q   <= '0;
            seen_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_packet_q <= TX_ACK;
        end else begin
            tx_start_q <= 1'b0;
            if (tx_load) tx_ctrl_q <= bus.wdata[2:0];
            unique case (tx_state_q)
                TX_IDLE: if (tx_ctrl_q != '0) tx_state_q <= TX_ARM;
                TX_ARM: if (tx_go) begin
                    tx_state_q  <= TX_LAUNCH;
                    tx_start_q  <= 1'b1;
                    tx_packet_q <= tx_map(tx_ctrl_q);
                end
                TX_LAUNCH: begin
                    tx_state_q  <= TX_ACTIVE;
                    seen_q      <= tx_transfer_active;
                    tx_packet_q <= TX_ACK;
                end
                TX_ACTIVE: begin
                    if (tx_transfer_active) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        tx_ctrl_q  <= '0;
                        tx_state_q <= TX_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef USB_EP_IRQ_EN
    logic [8:0] mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '0;
        else if (wr && sel == SEL_IRQ_MASK) mask_q <= bus.wdata[8:0] & 9'h11F;
    end

    assign irq = |(status_q & mask_q[4:0]) | (mask_q[8] & |error_q);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rmux = '0;
        case (sel)
            SEL_STATUS:  rmux = DATA_W'({tx_transfer_active,
                                         rx_transfer_active, status_q});
            SEL_ERROR:   rmux = DATA_W'(error_q);
            SEL_OCCUP:   rmux = DATA_W'(buffer_occupancy);
            SEL_TX_CTRL: rmux = DATA_W'(tx_ctrl_q);
            SEL_FLUSH:   rmux = DATA_W'(flush_q);
`ifdef USB_EP_IRQ_EN
            SEL_IRQ_MASK: rmux = DATA_W'(mask_q);
`endif
            default:     rmux = '0;
        endcase
    end

    // DATA reads that underflow complete here with zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv_q <= rd & (~is_data | unf);
            if (rd) rdata_q <= rmux;
        end
    end

    assign bus.rdata       = ser_done ? ser_rdata : rdata_q;
    assign bus.rdata_valid = ser_done | rv_q;
    assign bus.busy        = ser_busy | flush_q;
    assign clear           = flush_q;
    assign tx_start        = tx_start_q;
    assign tx_packet       = tx_packet_q;
    assign d_mode          = tx_transfer_active;
endmodule

// File: tb/tb_usb_ep_reg_bank.sv
// tb_usb_ep_reg_bank: directed self-checking bench for the endpoint
// register bank, default build (USB_EP_IRQ_EN undefined).
module tb_usb_ep_reg_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx_packet = '0;
    logic       rx_data_ready = 1'b0;
    logic       rx_transfer_active = 1'b0;
    logic       rx_error = 1'b0;
    logic       tx_transfer_active = 1'b0;
    logic       tx_error = 1'b0;
    logic [6:0] buffer_occupancy = '0;
    logic [7:0] rx_data = '0;
    logic       get_rx_data, store_tx_data, tx_start, clear;
    logic       d_mode, irq;
    logic [7:0] tx_data;
    logic [1:0] tx_packet;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    usb_ep_reg_bank_if #(.DATA_W(32)) bif();

    usb_ep_reg_bank #(.DATA_W(32), .BUF_DEPTH(64), .OCC_W(7)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bif),
        .rx_packet          (rx_packet),
        .rx_data_ready      (rx_data_ready),
        .rx_transfer_active (rx_transfer_active),
        .rx_error           (rx_error),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .buffer_occupancy   (buffer_occupancy),
        .rx_data            (rx_data),
        .get_rx_data        (get_rx_data),
        .store_tx_data      (store_tx_data),
        .tx_data            (tx_data),
        .tx_packet          (tx_packet),
        .tx_start           (tx_start),
        .clear              (clear),
        .d_mode             (d_mode),
        .irq                (irq)
    );

    task automatic bus_op(input logic w, input logic [1:0] sz,
                          input logic [3:0] sel, input logic [31:0] d);
        int guard = 0;
        while (bif.busy === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout: busy=%b want 0", bif.busy);
        end
        bif.access_valid = 1'b1;
        bif.access_write = w;
        bif.access_size  = sz;
        bif.reg_sel      = sel;
        bif.wdata        = d;
        @(negedge clk);
        bif.access_valid = 1'b0;
        bif.access_write = 1'b0;
        bif.wdata        = '0;
    endtask

    task automatic reg_read(input logic [3:0] sel,
                            output logic [31:0] d, output logic v);
        bus_op(1'b0, 2'd2, sel, 32'h0);
        d = bif.rdata;
        v = bif.rdata_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        @(negedge clk);
        n_cmp++;
        if ({bif.busy, bif.rdata_valid, store_tx_data, get_rx_data,
             tx_start, clear, d_mode, irq} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 00000000",
                     {bif.busy, bif.rdata_valid, store_tx_data,
                      get_rx_data, tx_start, clear, d_mode, irq});
        end
        n_cmp++;
        if (bif.rdata !== 32'h0 || tx_data !== 8'h0 || tx_packet !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h tx_data=%h pkt=%0d want 0",
                     bif.rdata, tx_data, tx_packet);
        end
        rst = 1'b0;
        @(negedge clk);
        reg_read(4'd2, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_error: got v=%b %h want 1 0", v, d);
        end
        buffer_occupancy = 7'd37;
        reg_read(4'd3, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h25) begin
            n_fail++;
            $display("FAIL occup_read: got v=%b %h want 1 25", v, d);
        end
        buffer_occupancy = 7'd0;
        reg_read(4'd9, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: got v=%b %h want 1 0", v, d);
        end
    endtask

    task automatic test_data_write();
        logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [31:0] d;
        logic v;
        buffer_occupancy = 7'd0;
        bus_op(1'b1, 2'd2, 4'd0, 32'hDDCCBBAA);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (bif.busy !== 1'b1 || store_tx_data !== 1'b1 || tx_data !== exp_b[k]) begin
                n_fail++;
                $display("FAIL wr_push%0d: busy=%b push=%b data=%h want 1 1 %h",
                         k, bif.busy, store_tx_data, tx_data, exp_b[k]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bif.busy !== 1'b0 || store_tx_data !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_end: busy=%b push=%b want 0 0", bif.busy, store_tx_data);
        end
        reg_read(4'd2, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_noerr: got %h want 0", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic v;
        buffer_occupancy = 7'd62;
        bus_op(1'b1, 2'd2, 4'd0, 32'h12345678);
        n_cmp++;
        if (bif.busy !== 1'b0 || store_tx_data !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_nopush: busy=%b push=%b want 0 0", bif.busy, store_tx_data);
        end
        reg_read(4'd2, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h4) begin
            n_fail++;
            $display("FAIL ovf_err1: got v=%b %h want 1 4", v, d);
        end
        reg_read(4'd2, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL ovf_err2: got v=%b %h want 1 0", v, d);
        end
        buffer_occupancy = 7'd0;
    endtask

    task automatic test_data_read();
        logic [31:0] d;
        logic v;
        buffer_occupancy = 7'd3;
        rx_data = 8'h11;
        bus_op(1'b0, 2'd1, 4'd0, 32'h0);
        n_cmp++;
        if (get_rx_data !== 1'b1 || bif.rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_pop0: pop=%b rv=%b want 1 0", get_rx_data, bif.rdata_valid);
        end
        @(negedge clk);
        rx_data = 8'h22;
        n_cmp++;
        if (get_rx_data !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_pop1: pop=%b want 1", get_rx_data);
        end
        @(negedge clk);
        rx_data = 8'h33;
        n_cmp++;
        if (get_rx_data !== 1'b0 || bif.rdata_valid !== 1'b1 || bif.rdata !== 32'h2211) begin
            n_fail++;
            $display("FAIL rd_data: pop=%b rv=%b rdata=%h want 0 1 2211",
                     get_rx_data, bif.rdata_valid, bif.rdata);
        end
        @(negedge clk);
        buffer_occupancy = 7'd1;
        bus_op(1'b0, 2'd1, 4'd0, 32'h0);
        n_cmp++;
        if (get_rx_data !== 1'b0 || bif.rdata_valid !== 1'b1 || bif.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL unf_resp: pop=%b rv=%b rdata=%h want 0 1 0",
                     get_rx_data, bif.rdata_valid, bif.rdata);
        end
        reg_read(4'd2, d, v);
        n_cmp++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("FAIL unf_err: got %h want 8", d);
        end
        buffer_occupancy = 7'd0;
    endtask

    task automatic test_status();
        logic [31:0] d;
        logic v;
        rx_packet = 3'd4;
        rx_data_ready = 1'b1;
        reg_read(4'd1, d, v);
        rx_data_ready = 1'b0;
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL st_old: got v=%b %h want 1 0", v, d);
        end
        reg_read(4'd1, d, v);
        n_cmp++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("FAIL st_ack: got %h want 8", d);
        end
        reg_read(4'd1, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL st_cleared: got %h want 0", d);
        end
        rx_packet = 3'd1;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        reg_read(4'd1, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL st_in: got %h want 2", d);
        end
        buffer_occupancy = 7'd5;
        rx_packet = 3'd3;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        rx_transfer_active = 1'b1;
        reg_read(4'd1, d, v);
        reg_read(4'd1, d, v);
        n_cmp++;
        if (d !== 32'h21) begin
            n_fail++;
            $display("FAIL st_rdy_live: got %h want 21", d);
        end
        buffer_occupancy = 7'd0;
        @(negedge clk);
        reg_read(4'd1, d, v);
        n_cmp++;
        if (d !== 32'h20) begin
            n_fail++;
            $display("FAIL st_rdy_clr: got %h want 20", d);
        end
        rx_transfer_active = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_off: got %b want 0", irq);
        end
    endtask

    task automatic test_tx_ctrl();
        logic [31:0] d;
        logic v;
        int seen_start = 0;
        buffer_occupancy = 7'd0;
        bus_op(1'b1, 2'd2, 4'd4, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (tx_start === 1'b1) seen_start++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_start != 0) begin
            n_fail++;
            $display("FAIL tx_wait_occ: starts=%0d want 0", seen_start);
        end
        buffer_occupancy = 7'd5;
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b1 || tx_packet !== 2'd2) begin
            n_fail++;
            $display("FAIL tx_launch: start=%b pkt=%0d want 1 2", tx_start, tx_packet);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_pulse: start=%b want 0", tx_start);
        end
        reg_read(4'd4, d, v);
        n_cmp++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL tx_ctrl_held: got %h want 1", d);
        end
        tx_transfer_active = 1'b1;
        #1;
        n_cmp++;
        if (d_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL d_mode: got %b want 1", d_mode);
        end
        @(negedge clk);
        @(negedge clk);
        tx_transfer_active = 1'b0;
        @(negedge clk);
        reg_read(4'd4, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL tx_ctrl_done: got %h want 0", d);
        end
        bus_op(1'b1, 2'd2, 4'd4, 32'd5);
        reg_read(4'd4, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL tx_bad_code: got %h want 0", d);
        end
        buffer_occupancy = 7'd0;
        bus_op(1'b1, 2'd2, 4'd4, 32'd4);
        for (int i = 0; i < 10; i++) begin
            if (tx_start === 1'b1) break;
            @(negedge clk);
        end
        n_cmp++;
        if (tx_start !== 1'b1 || tx_packet !== 2'd3) begin
            n_fail++;
            $display("FAIL tx_stall: start=%b pkt=%0d want 1 3", tx_start, tx_packet);
        end
        @(negedge clk);
        tx_transfer_active = 1'b1;
        @(negedge clk);
        tx_transfer_active = 1'b0;
        @(negedge clk);
        reg_read(4'd4, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL tx_stall_done: got %h want 0", d);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic v;
        buffer_occupancy = 7'd3;
        bus_op(1'b1, 2'd2, 4'd5, 32'd1);
        for (int k = 2; k >= 0; k--) begin
            n_cmp++;
            if (clear !== 1'b1 || bif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_hold%0d: clear=%b busy=%b want 1 1",
                         k, clear, bif.busy);
            end
            buffer_occupancy = 7'(k);
            @(negedge clk);
        end
        n_cmp++;
        if (clear !== 1'b0 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: clear=%b busy=%b want 0 0", clear, bif.busy);
        end
        reg_read(4'd5, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_read: got v=%b %h want 1 0", v, d);
        end
    endtask

    task automatic test_rst_midburst();
        buffer_occupancy = 7'd0;
        bus_op(1'b1, 2'd2, 4'd0, 32'h44332211);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bif.busy, bif.rdata_valid, store_tx_data, get_rx_data,
             tx_start, clear, irq} !== 7'h00 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid: outs=%b tx_data=%h want 0 0",
                     {bif.busy, bif.rdata_valid, store_tx_data, get_rx_data,
                      tx_start, clear, irq}, tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (store_tx_data !== 1'b0 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abandon: push=%b busy=%b want 0 0",
                     store_tx_data, bif.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bif.access_valid = 1'b0;
        bif.access_write = 1'b0;
        bif.access_size  = 2'd0;
        bif.reg_sel      = 4'd0;
        bif.wdata        = 32'h0;
        test_reset();
        test_data_write();
        test_overflow();
        test_data_read();
        test_status();
        test_tx_ctrl();
        test_flush();
        test_rst_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
